// File: rtl/retire_trace_writer.sv
// retire_trace_writer
// Captures each instruction retiring out of MEM/WB, stamps it with a free-running
// cycle counter and buffers it in a small circular FIFO that a reader drains over
// a valid/ready port. The last free slot is held back for the HLT record so the
// halt is never lost. Completion is flagged once the reader takes the HLT record.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_RUN   | normal capture; non-halt records may use all but one slot
// S_DRAIN | HLT buffered; new retires are ignored and not counted as drops
// S_DONE  | HLT record consumed by the reader; absorbing until rst

module retire_trace_writer #(
   parameter int DEPTH = 8,
   parameter int CW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     retire_valid,
   input  logic [15:0]              retire_pc,
   input  logic [15:0]              retire_inst,
   input  logic                     retire_we,
   input  logic [3:0]               retire_rd,
   input  logic [15:0]              retire_wdata,
   input  logic                     retire_hlt,
   output logic                     trace_valid,
   input  logic                     trace_ready,
   output logic [53+CW:0]           trace_rec,
   output logic [$clog2(DEPTH):0]   trace_count,
   output logic                     overflow,
   output logic [15:0]              drop_count,
   output logic                     trace_done
);

   localparam int AW = $clog2(DEPTH);
   localparam int RW = 54 + CW;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_NH   = (AW+1)'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DRAIN = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t          state;
   logic [CW-1:0]   cyc;
   logic [RW-1:0]   mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic [RW-1:0]   in_rec;
   logic            pop;
   logic            want;
   logic            room_nh;
   logic            room_h;
   logic            push;
   logic            reject;
   logic            head_hlt;

   // The stamp is the counter value before the sampling edge increments it.
   assign in_rec = {cyc, retire_pc, retire_inst, retire_we, retire_rd,
                    retire_wdata, retire_hlt};

   // Output side is driven purely from stored state; an empty FIFO shows zero.
   assign trace_valid = (count != '0);
   assign trace_rec   = trace_valid ? mem[rd_ptr] : '0;
   assign trace_count = count;
   assign head_hlt    = mem[rd_ptr][0];
   assign pop         = trace_valid & trace_ready;

   // Admission: a pop on the same edge frees a slot, so it always permits a push.
   always_comb begin
      want    = retire_valid & (state == S_RUN);
      room_nh = (count < CNT_NH) | pop;
      room_h  = (count < CNT_FULL) | pop;
      push    = want & (retire_hlt ? room_h : room_nh);
      reject  = want & ~push;
   end

   // Free-running cycle stamp, wraps modulo 2^CW.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cyc <= '0;
      else
         cyc <= cyc + 1'b1;
   end

   // Record storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_rec;
   end

   // Pointers and occupancy; push and pop together leave occupancy unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag and saturating drop counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (reject) begin
         overflow <= 1'b1;
         if (drop_count != 16'hFFFF)
            drop_count <= drop_count + 1'b1;
      end
   end

   // Sequencing FSM with registered completion flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_RUN;
         trace_done <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               if (push & retire_hlt)
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (pop & head_hlt) begin
                  state      <= S_DONE;
                  trace_done <= 1'b1;
               end
            end
            S_DONE: begin
               state      <= S_DONE;
               trace_done <= 1'b1;
            end
            default: state <= S_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_retire_trace_writer.sv
// Testbench for retire_trace_writer: directed retires, scoreboard-checked trace port.
`timescale 1ns/1ps
module tb_retire_trace_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        retire_valid = 1'b0;
   logic [15:0] retire_pc = '0;
   logic [15:0] retire_inst = '0;
   logic        retire_we = 1'b0;
   logic [3:0]  retire_rd = '0;
   logic [15:0] retire_wdata = '0;
   logic        retire_hlt = 1'b0;
   logic        trace_valid;
   logic        trace_ready = 1'b0;
   logic [85:0] trace_rec;
   logic [3:0]  trace_count;
   logic        overflow;
   logic [15:0] drop_count;
   logic        trace_done;

   // narrow-stamp instance for the wrap test
   logic        rst_w = 1'b1;
   logic        rv_w = 1'b0;
   logic [15:0] pc_w = '0;
   logic        w_valid;
   logic [57:0] w_rec;
   logic [3:0]  w_count;
   logic        w_ovf;
   logic [15:0] w_drop;
   logic        w_done;

   int n_vec = 0;
   int n_err = 0;
   int w_seen = 0;
   logic [31:0] tb_cyc = '0;
   logic [85:0] exp_q[$];
   logic [19:0] exp_w[$];

   always #5 clk = ~clk;

   retire_trace_writer #(.DEPTH(8), .CW(32)) u_dut (
      .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
      .retire_inst(retire_inst), .retire_we(retire_we), .retire_rd(retire_rd),
      .retire_wdata(retire_wdata), .retire_hlt(retire_hlt), .trace_valid(trace_valid),
      .trace_ready(trace_ready), .trace_rec(trace_rec), .trace_count(trace_count),
      .overflow(overflow), .drop_count(drop_count), .trace_done(trace_done));

   retire_trace_writer #(.DEPTH(8), .CW(4)) u_wrap (
      .clk(clk), .rst(rst_w), .retire_valid(rv_w), .retire_pc(pc_w),
      .retire_inst(16'h0000), .retire_we(1'b0), .retire_rd(4'h0),
      .retire_wdata(16'h0000), .retire_hlt(1'b0), .trace_valid(w_valid),
      .trace_ready(1'b1), .trace_rec(w_rec), .trace_count(w_count),
      .overflow(w_ovf), .drop_count(w_drop), .trace_done(w_done));

   // reference cycle count: edges seen since reset release
   always @(posedge clk or posedge rst) begin
      if (rst) tb_cyc <= '0;
      else     tb_cyc <= tb_cyc + 1;
   end

   function automatic logic [85:0] pack(input logic [31:0] c, input logic [15:0] pc,
                                        input logic [15:0] inst, input logic we,
                                        input logic [3:0] rd, input logic [15:0] wd,
                                        input logic hlt);
      return {c, pc, inst, we, rd, wd, hlt};
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic retire(input logic [15:0] pc, input logic [15:0] inst, input logic we,
                         input logic [3:0] rd, input logic [15:0] wd, input logic hlt,
                         input bit acc);
      retire_valid = 1'b1;
      retire_pc    = pc;
      retire_inst  = inst;
      retire_we    = we;
      retire_rd    = rd;
      retire_wdata = wd;
      retire_hlt   = hlt;
      if (acc) exp_q.push_back(pack(tb_cyc, pc, inst, we, rd, wd, hlt));
      @(posedge clk); #1;
      retire_valid = 1'b0;
      retire_hlt   = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic drain_to_done(input string nm);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         check({nm, "_done_early"}, trace_done, 1'b0);
         @(posedge clk); #1;
      end
      check({nm, "_drain_left"}, exp_q.size(), 0);
      check({nm, "_done"}, trace_done, 1'b1);
      check({nm, "_count_empty"}, trace_count, 4'd0);
   endtask

   // scoreboard monitor, main instance
   always @(negedge clk) begin
      if (!rst && trace_valid && trace_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL mon_unexpected: got %h expected no record", trace_rec);
         end else begin
            check("mon_rec", trace_rec, exp_q.pop_front());
         end
      end
   end

   // scoreboard monitor, narrow-stamp instance (stamp, pc)
   always @(negedge clk) begin
      if (!rst_w && w_valid) begin
         w_seen++;
         if (exp_w.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL wrap_unexpected: got %h expected no record", w_rec);
         end else begin
            check("wrap_stamp_pc", w_rec[57:38], exp_w.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [85:0] first;
      logic [3:0]  stamp_tab [4];
      stamp_tab[0] = 4'd14; stamp_tab[1] = 4'd15; stamp_tab[2] = 4'd0; stamp_tab[3] = 4'd1;

      // reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", trace_valid, 1'b0);
      check("rst_rec", trace_rec, 86'h0);
      check("rst_count", trace_count, 4'd0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_drop", drop_count, 16'h0);
      check("rst_done", trace_done, 1'b0);
      rst = 1'b0;

      // single retire sampled at counter 5
      repeat (5) begin @(posedge clk); #1; end
      trace_ready = 1'b1;
      retire(16'h0002, 16'hA123, 1'b1, 4'd3, 16'h0042, 1'b0, 1'b1);
      check("single_valid", trace_valid, 1'b1);
      check("single_rec", trace_rec,
            {32'd5, 16'h0002, 16'hA123, 1'b1, 4'd3, 16'h0042, 1'b0});
      @(posedge clk); #1;
      check("single_valid_drop", trace_valid, 1'b0);
      trace_ready = 1'b0;

      // backpressure: 7 accepted, 2 dropped, head stable
      first = pack(tb_cyc, 16'h0100, 16'h1000, 1'b1, 4'd1, 16'h0001, 1'b0);
      for (int i = 0; i < 9; i++) begin
         retire(16'h0100 + 16'(i), 16'h1000 + 16'(i), 1'b1, 4'(i + 1), 16'(i + 1), 1'b0, i < 7);
         check("bp_head_stable", trace_rec, first);
         if (i == 6) begin
            check("bp_count7", trace_count, 4'd7);
            check("bp_no_ovf_yet", overflow, 1'b0);
         end
      end
      check("bp_count_after", trace_count, 4'd7);
      check("bp_ovf", overflow, 1'b1);
      check("bp_drop2", drop_count, 16'd2);

      // reserved slot takes HLT, then retires are ignored
      retire(16'h0200, 16'hF000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1);
      check("hlt_count8", trace_count, 4'd8);
      retire(16'h0204, 16'h2222, 1'b1, 4'd5, 16'h5555, 1'b0, 1'b0);
      check("drain_ignore_count", trace_count, 4'd8);
      check("drain_ignore_drop", drop_count, 16'd2);
      trace_ready = 1'b1;
      drain_to_done("hlt");
      retire(16'h0300, 16'h3333, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
      check("done_no_enq", trace_valid, 1'b0);
      check("done_sticky", trace_done, 1'b1);

      // reset mid-stream with 5 buffered and overflow set
      trace_ready = 1'b0;
      pulse_reset();
      check("rst_clears_done", trace_done, 1'b0);
      for (int i = 0; i < 8; i++)
         retire(16'h0400 + 16'(i), 16'h4000, 1'b0, 4'd0, 16'(i), 1'b0, i < 7);
      trace_ready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      trace_ready = 1'b0;
      check("mid_count5", trace_count, 4'd5);
      check("mid_ovf", overflow, 1'b1);
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      check("async_valid", trace_valid, 1'b0);
      check("async_rec", trace_rec, 86'h0);
      check("async_count", trace_count, 4'd0);
      check("async_ovf", overflow, 1'b0);
      check("async_drop", drop_count, 16'h0);
      check("async_done", trace_done, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      trace_ready = 1'b1;
      retire(16'h0500, 16'h5000, 1'b1, 4'd7, 16'h7777, 1'b0, 1'b1);
      check("post_rst_stamp", trace_rec[85:54], 32'd0);
      @(posedge clk); #1;

      // near-full with simultaneous push and pop, non-halt then HLT
      trace_ready = 1'b0;
      for (int i = 0; i < 7; i++)
         retire(16'h0600 + 16'(i), 16'h6000, 1'b1, 4'd2, 16'h0600 + 16'(i), 1'b0, 1'b1);
      trace_ready = 1'b1;
      retire(16'h0610, 16'h6100, 1'b1, 4'd2, 16'h0610, 1'b0, 1'b1);
      check("pp_count7", trace_count, 4'd7);
      check("pp_no_drop", drop_count, 16'd0);
      retire(16'h0620, 16'hF000, 1'b0, 4'd0, 16'h0, 1'b1, 1'b1);
      check("pp_hlt_count7", trace_count, 4'd7);
      check("pp_hlt_no_drop", overflow, 1'b0);
      drain_to_done("pp");

      // pointer wrap across 3*DEPTH back-to-back records
      pulse_reset();
      trace_ready = 1'b1;
      for (int i = 0; i < 24; i++)
         retire(16'h0700 + 16'(i), 16'h7000 + 16'(i), i[0], 4'(i), 16'(i * 3), 1'b0, 1'b1);
      retire(16'h0720, 16'hF000, 1'b0, 4'd0, 16'h0, 1'b1, 1'b1);
      drain_to_done("wrap_ptr");
      check("wrap_ptr_drop", drop_count, 16'd0);

      // 4-bit stamp wrap on the narrow instance
      rst_w = 1'b0;
      for (int c = 0; c < 20; c++) begin
         rv_w = (c >= 14 && c <= 17);
         pc_w = 16'(c);
         if (rv_w) exp_w.push_back({stamp_tab[c - 14], 16'(c)});
         @(posedge clk); #1;
      end
      rv_w = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("wrap_seen", w_seen, 4);
      check("wrap_left", exp_w.size(), 0);
      check("wrap_count", w_count, 4'd0);
      check("wrap_ovf", {w_ovf, w_drop, w_done}, 18'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
